// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register sitting directly in front of the ALU.
// Captures a decoded instruction and its register-file operands. It decodes
// opcode/funct3/funct7 into the 4-bit ALU control code and resolves operand
// forwarding from EX/MEM and MEM/WB. The ALU-side entry appears one cycle after
// it is accepted.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready decode-side handshake (in_ready = !out_valid || out_ready)
//   instr             raw instruction word
//   rs1_data/rs2_data register-file read data
//   exm_*             EX/MEM write-back bypass (highest forwarding priority)
//   wb_*              MEM/WB write-back bypass
//   flush             kills the held entry and drops the incoming one
//   out_valid/out_ready ALU-side handshake
//   alu_in_a/alu_in_b/alu_control  operands and operation for the ALU
//   rd, reg_write     destination register and write enable
//   illegal           instruction is not executable by this stage
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            exm_reg_write,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_in_a,
    output logic [XLEN-1:0] alu_in_b,
    output logic [3:0]      alu_control,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            illegal
);

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;

    // Operand source select shared by fresh decode and held-entry refresh:
    // x0 always reads zero, EX/MEM beats MEM/WB, otherwise the fallback value.
    function automatic logic [XLEN-1:0] select_operand(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] fallback,
        input logic            exm_we,
        input logic [4:0]      exm_idx,
        input logic [XLEN-1:0] exm_val,
        input logic            wb_we,
        input logic [4:0]      wb_idx,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] result;
        if (idx == 5'd0) begin
            result = {XLEN{1'b0}};
        end else if (exm_we && (exm_idx == idx)) begin
            result = exm_val;
        end else if (wb_we && (wb_idx == idx)) begin
            result = wb_val;
        end else begin
            result = fallback;
        end
        return result;
    endfunction

    // Stored entry
    logic            valid_r;
    logic [XLEN-1:0] alu_in_a_r;
    logic [XLEN-1:0] alu_in_b_r;
    logic [3:0]      alu_control_r;
    logic [4:0]      rd_r;
    logic            reg_write_r;
    logic            illegal_r;
    // Source indices and "operand came from a register" flags kept for refresh
    logic [4:0]      rs1_idx_r;
    logic [4:0]      rs2_idx_r;
    logic            a_fwd_r;
    logic            b_fwd_r;

    // Instruction fields
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;

    // Decode results
    logic            dec_legal_s;
    logic            dec_is_r_s;
    logic            dec_is_shift_s;
    logic [3:0]      dec_ctrl_s;
    logic [XLEN-1:0] dec_a_s;
    logic [XLEN-1:0] dec_b_s;

    // Held-entry refresh values and handshake terms
    logic [XLEN-1:0] held_a_s;
    logic [XLEN-1:0] held_b_s;
    logic            load_s;
    logic            hold_s;

    assign opcode_s = instr[6:0];
    assign rd_s     = instr[11:7];
    assign funct3_s = instr[14:12];
    assign rs1_s    = instr[19:15];
    assign rs2_s    = instr[24:20];
    assign funct7_s = instr[31:25];

    assign in_ready = !valid_r || out_ready;
    assign load_s   = in_valid && in_ready;
    assign hold_s   = valid_r && !out_ready;

    // Opcode/funct decode into legality, ALU code and operand-B kind
    always_comb begin
        dec_legal_s    = 1'b0;
        dec_is_r_s     = 1'b0;
        dec_is_shift_s = 1'b0;
        dec_ctrl_s     = 4'b0010;
        case (opcode_s)
            OP_R_TYPE: begin
                dec_is_r_s  = 1'b1;
                dec_legal_s = 1'b1;
                case ({funct7_s, funct3_s})
                    10'b0000000_000: dec_ctrl_s = 4'b0010;
                    10'b0100000_000: dec_ctrl_s = 4'b0100;
                    10'b0000000_001: dec_ctrl_s = 4'b0011;
                    10'b0000000_010: dec_ctrl_s = 4'b1000;
                    10'b0000000_100: dec_ctrl_s = 4'b0111;
                    10'b0000000_101: dec_ctrl_s = 4'b0101;
                    10'b0000000_110: dec_ctrl_s = 4'b0001;
                    10'b0000000_111: dec_ctrl_s = 4'b0000;
                    10'b0000001_000: dec_ctrl_s = 4'b0110;
                    default: begin
                        dec_legal_s = 1'b0;
                        dec_ctrl_s  = 4'b0010;
                    end
                endcase
            end
            OP_I_TYPE: begin
                dec_legal_s = 1'b1;
                case (funct3_s)
                    3'b000: dec_ctrl_s = 4'b0010;
                    3'b010: dec_ctrl_s = 4'b1000;
                    3'b100: dec_ctrl_s = 4'b0111;
                    3'b110: dec_ctrl_s = 4'b0001;
                    3'b111: dec_ctrl_s = 4'b0000;
                    3'b001: begin
                        dec_is_shift_s = 1'b1;
                        if (funct7_s == 7'b0000000) begin
                            dec_ctrl_s = 4'b0011;
                        end else begin
                            dec_legal_s = 1'b0;
                            dec_ctrl_s  = 4'b0010;
                        end
                    end
                    3'b101: begin
                        dec_is_shift_s = 1'b1;
                        if (funct7_s == 7'b0000000) begin
                            dec_ctrl_s = 4'b0101;
                        end else begin
                            dec_legal_s = 1'b0;
                            dec_ctrl_s  = 4'b0010;
                        end
                    end
                    default: begin
                        dec_legal_s = 1'b0;
                        dec_ctrl_s  = 4'b0010;
                    end
                endcase
            end
            default: begin
                dec_legal_s = 1'b0;
                dec_ctrl_s  = 4'b0010;
            end
        endcase
    end

    // Operand build for a fresh entry; immediates never take the bypass
    always_comb begin
        dec_a_s = {XLEN{1'b0}};
        dec_b_s = {XLEN{1'b0}};
        if (dec_legal_s) begin
            dec_a_s = select_operand(rs1_s, rs1_data, exm_reg_write, exm_rd, exm_result,
                                     wb_reg_write, wb_rd, wb_result);
            if (dec_is_r_s) begin
                dec_b_s = select_operand(rs2_s, rs2_data, exm_reg_write, exm_rd, exm_result,
                                         wb_reg_write, wb_rd, wb_result);
            end else if (dec_is_shift_s) begin
                dec_b_s = {{(XLEN-5){1'b0}}, instr[24:20]};
            end else begin
                dec_b_s = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
        end else begin
            dec_a_s = {XLEN{1'b0}};
            dec_b_s = {XLEN{1'b0}};
        end
    end

    // Refresh of a stalled entry: a late write to a source register updates it
    always_comb begin
        held_a_s = alu_in_a_r;
        held_b_s = alu_in_b_r;
        if (a_fwd_r) begin
            held_a_s = select_operand(rs1_idx_r, alu_in_a_r, exm_reg_write, exm_rd, exm_result,
                                      wb_reg_write, wb_rd, wb_result);
        end else begin
            held_a_s = alu_in_a_r;
        end
        if (b_fwd_r) begin
            held_b_s = select_operand(rs2_idx_r, alu_in_b_r, exm_reg_write, exm_rd, exm_result,
                                      wb_reg_write, wb_rd, wb_result);
        end else begin
            held_b_s = alu_in_b_r;
        end
    end

    // Pipeline register: reset > flush > load > hold-refresh > drain
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r       <= 1'b0;
            alu_in_a_r    <= {XLEN{1'b0}};
            alu_in_b_r    <= {XLEN{1'b0}};
            alu_control_r <= 4'b0000;
            rd_r          <= 5'd0;
            reg_write_r   <= 1'b0;
            illegal_r     <= 1'b0;
            rs1_idx_r     <= 5'd0;
            rs2_idx_r     <= 5'd0;
            a_fwd_r       <= 1'b0;
            b_fwd_r       <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load_s) begin
            valid_r       <= 1'b1;
            alu_in_a_r    <= dec_a_s;
            alu_in_b_r    <= dec_b_s;
            alu_control_r <= dec_legal_s ? dec_ctrl_s : 4'b0010;
            rd_r          <= dec_legal_s ? rd_s : 5'd0;
            reg_write_r   <= dec_legal_s && (rd_s != 5'd0);
            illegal_r     <= !dec_legal_s;
            rs1_idx_r     <= rs1_s;
            rs2_idx_r     <= rs2_s;
            a_fwd_r       <= dec_legal_s;
            b_fwd_r       <= dec_legal_s && dec_is_r_s;
        end else if (hold_s) begin
            alu_in_a_r <= held_a_s;
            alu_in_b_r <= held_b_s;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign out_valid   = valid_r;
    assign alu_in_a    = alu_in_a_r;
    assign alu_in_b    = alu_in_b_r;
    assign alu_control = alu_control_r;
    assign rd          = rd_r;
    assign reg_write   = reg_write_r;
    assign illegal     = illegal_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps from the test plan
// followed by random traffic, compared against an entry-level reference model.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            exm_reg_write;
    logic [4:0]      exm_rd;
    logic [XLEN-1:0] exm_result;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_result;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_in_a;
    logic [XLEN-1:0] alu_in_b;
    logic [3:0]      alu_control;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;

    int n_assert = 0;
    int n_fail   = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_control(alu_control),
        .rd(rd), .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Table of supported operations: opcode, funct7 (when it matters), funct3, ALU code
    typedef struct packed {
        logic [6:0] op;
        logic [6:0] f7;
        logic       f7_care;
        logic [2:0] f3;
        logic [3:0] ctrl;
    } op_t;
    op_t optab [16];

    // Expected ALU-side entry
    typedef struct {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        a_fw;
        logic        b_fw;
    } ent_t;
    ent_t m;

    function automatic ent_t zero_entry();
        ent_t e;
        e.valid = 1'b0; e.a = 32'd0; e.b = 32'd0; e.ctrl = 4'd0; e.rd = 5'd0;
        e.rw = 1'b0; e.ill = 1'b0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.a_fw = 1'b0; e.b_fw = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] pick(input logic [4:0] idx, input logic [31:0] base);
        if (idx == 5'd0) return 32'd0;
        if (exm_reg_write && exm_rd == idx) return exm_result;
        if (wb_reg_write && wb_rd == idx) return wb_result;
        return base;
    endfunction

    function automatic ent_t fresh_entry();
        ent_t e;
        logic hit;
        logic [3:0] ctrl;
        e = zero_entry();
        hit = 1'b0;
        ctrl = 4'b0010;
        for (int k = 0; k < 16; k++) begin
            if (optab[k].op == instr[6:0] && optab[k].f3 == instr[14:12] &&
                (!optab[k].f7_care || optab[k].f7 == instr[31:25])) begin
                hit = 1'b1;
                ctrl = optab[k].ctrl;
            end
        end
        e.valid = 1'b1;
        if (!hit) begin
            e.ill = 1'b1;
            e.ctrl = 4'b0010;
            return e;
        end
        e.ctrl = ctrl;
        e.rd   = instr[11:7];
        e.rw   = (instr[11:7] != 5'd0);
        e.rs1  = instr[19:15];
        e.rs2  = instr[24:20];
        e.a    = pick(e.rs1, rs1_data);
        e.a_fw = 1'b1;
        if (instr[6:0] == 7'b0110011) begin
            e.b    = pick(e.rs2, rs2_data);
            e.b_fw = 1'b1;
        end else if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
            e.b = {27'd0, instr[24:20]};
        end else begin
            e.b = {{20{instr[31]}}, instr[31:20]};
        end
        return e;
    endfunction

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {imm, s1, f3, d, 7'b0010011};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        ent_t nx;
        nx = m;
        if (rst) begin
            nx = zero_entry();
        end else if (flush) begin
            nx.valid = 1'b0;
        end else if (in_valid && (!m.valid || out_ready)) begin
            nx = fresh_entry();
        end else if (m.valid && !out_ready) begin
            if (m.a_fw) nx.a = pick(m.rs1, m.a);
            if (m.b_fw) nx.b = pick(m.rs2, m.b);
        end else begin
            nx.valid = 1'b0;
        end
        @(posedge clk);
        #1;
        m = nx;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m.valid});
        check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, (!m.valid || out_ready)});
        if (m.valid) begin
            check({tag, ".a"}, alu_in_a, m.a);
            check({tag, ".b"}, alu_in_b, m.b);
            check({tag, ".ctrl"}, {28'd0, alu_control}, {28'd0, m.ctrl});
            check({tag, ".rw"}, {31'd0, reg_write}, {31'd0, m.rw});
            check({tag, ".ill"}, {31'd0, illegal}, {31'd0, m.ill});
            if (!m.ill) check({tag, ".rd"}, {27'd0, rd}, {27'd0, m.rd});
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".a"}, alu_in_a, 32'd0);
        check({tag, ".b"}, alu_in_b, 32'd0);
        check({tag, ".ctrl"}, {28'd0, alu_control}, 32'd0);
        check({tag, ".rd"}, {27'd0, rd}, 32'd0);
        check({tag, ".rw"}, {31'd0, reg_write}, 32'd0);
        check({tag, ".ill"}, {31'd0, illegal}, 32'd0);
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        optab[0]  = '{7'b0110011, 7'h00, 1'b1, 3'b000, 4'b0010};
        optab[1]  = '{7'b0110011, 7'h20, 1'b1, 3'b000, 4'b0100};
        optab[2]  = '{7'b0110011, 7'h00, 1'b1, 3'b001, 4'b0011};
        optab[3]  = '{7'b0110011, 7'h00, 1'b1, 3'b010, 4'b1000};
        optab[4]  = '{7'b0110011, 7'h00, 1'b1, 3'b100, 4'b0111};
        optab[5]  = '{7'b0110011, 7'h00, 1'b1, 3'b101, 4'b0101};
        optab[6]  = '{7'b0110011, 7'h00, 1'b1, 3'b110, 4'b0001};
        optab[7]  = '{7'b0110011, 7'h00, 1'b1, 3'b111, 4'b0000};
        optab[8]  = '{7'b0110011, 7'h01, 1'b1, 3'b000, 4'b0110};
        optab[9]  = '{7'b0010011, 7'h00, 1'b0, 3'b000, 4'b0010};
        optab[10] = '{7'b0010011, 7'h00, 1'b0, 3'b010, 4'b1000};
        optab[11] = '{7'b0010011, 7'h00, 1'b0, 3'b100, 4'b0111};
        optab[12] = '{7'b0010011, 7'h00, 1'b0, 3'b110, 4'b0001};
        optab[13] = '{7'b0010011, 7'h00, 1'b0, 3'b111, 4'b0000};
        optab[14] = '{7'b0010011, 7'h00, 1'b1, 3'b001, 4'b0011};
        optab[15] = '{7'b0010011, 7'h00, 1'b1, 3'b101, 4'b0101};
        m = zero_entry();

        // Reset held for two cycles with a pending instruction
        rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
        instr = r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        rs1_data = 32'd10; rs2_data = 32'd5;
        exm_reg_write = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
        tick(); tick();
        check_zero("reset");

        // ADD x3,x1,x2
        rst = 1'b0; out_ready = 1'b1;
        tick();
        check_model("add");
        check("add.a_lit", alu_in_a, 32'h0000000A);
        check("add.b_lit", alu_in_b, 32'h00000005);
        check("add.rd_lit", {27'd0, rd}, 32'd3);

        // ADDI x5,x1,-1 then SLLI x5,x1,2
        instr = i_ins(12'hFFF, 5'd1, 3'b000, 5'd5);
        tick();
        check_model("addi");
        check("addi.b_lit", alu_in_b, 32'hFFFFFFFF);
        instr = i_ins(12'h002, 5'd1, 3'b001, 5'd5);
        tick();
        check_model("slli");
        check("slli.b_lit", alu_in_b, 32'h00000002);
        check("slli.ctrl_lit", {28'd0, alu_control}, 32'h3);

        // SUB x4,x1,x1 with both bypasses matching: EX/MEM wins
        instr = r_ins(7'h20, 5'd1, 5'd1, 3'b000, 5'd4);
        exm_reg_write = 1'b1; exm_rd = 5'd1; exm_result = 32'd7;
        wb_reg_write = 1'b1; wb_rd = 5'd1; wb_result = 32'd9;
        tick();
        check_model("sub_fwd");
        check("sub_fwd.a_lit", alu_in_a, 32'd7);
        check("sub_fwd.b_lit", alu_in_b, 32'd7);
        // rs1 = x0 with a write to x0 in flight: operand stays zero
        instr = r_ins(7'h20, 5'd1, 5'd0, 3'b000, 5'd4);
        exm_rd = 5'd0;
        tick();
        check_model("sub_x0");
        check("sub_x0.a_lit", alu_in_a, 32'd0);

        // Stall while holding SLT x6,x1,x2; late MEM/WB write to x2; then flush
        exm_reg_write = 1'b0; wb_reg_write = 1'b0;
        instr = r_ins(7'h00, 5'd2, 5'd1, 3'b010, 5'd6);
        tick();
        check_model("slt");
        out_ready = 1'b0;
        instr = r_ins(7'h00, 5'd2, 5'd1, 3'b000, 5'd9);
        tick();
        check_model("stall1");
        check("stall1.in_ready_lit", {31'd0, in_ready}, 32'd0);
        wb_reg_write = 1'b1; wb_rd = 5'd2; wb_result = 32'd20;
        tick();
        check_model("stall2");
        check("stall2.b_lit", alu_in_b, 32'd20);
        check("stall2.ctrl_lit", {28'd0, alu_control}, 32'h8);
        wb_reg_write = 1'b0; flush = 1'b1;
        tick();
        check_model("stall3_flush");
        check("flush.valid_lit", {31'd0, out_valid}, 32'd0);

        // Illegal word, then MUL and XOR back to back
        flush = 1'b0; out_ready = 1'b1;
        instr = 32'h00000073;
        tick();
        check_model("illegal");
        check("illegal.flag_lit", {31'd0, illegal}, 32'd1);
        instr = r_ins(7'h01, 5'd2, 5'd1, 3'b000, 5'd7);
        tick();
        check_model("mul");
        check("mul.ctrl_lit", {28'd0, alu_control}, 32'h6);
        instr = r_ins(7'h00, 5'd2, 5'd1, 3'b100, 5'd8);
        tick();
        check_model("xor");
        check("xor.ctrl_lit", {28'd0, alu_control}, 32'h7);

        // Reset while holding
        out_ready = 1'b0;
        tick();
        check_model("hold_pre_rst");
        rst = 1'b1;
        tick();
        check_zero("rst_mid_hold");
        rst = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(0, 17);
            if (sel < 16) begin
                instr = {(optab[sel].f7_care ? optab[sel].f7 : 7'($urandom)),
                         (optab[sel].op == 7'b0110011 ? 5'($urandom_range(0, 3)) : 5'($urandom)),
                         5'($urandom_range(0, 3)), optab[sel].f3,
                         5'($urandom_range(0, 3)), optab[sel].op};
            end else begin
                instr = $urandom;
            end
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            rst           = ($urandom_range(0, 63) == 0);
            rs1_data      = $urandom;
            rs2_data      = $urandom;
            exm_reg_write = $urandom_range(0, 1) != 0;
            exm_rd        = 5'($urandom_range(0, 3));
            exm_result    = $urandom;
            wb_reg_write  = $urandom_range(0, 1) != 0;
            wb_rd         = 5'($urandom_range(0, 3));
            wb_result     = $urandom;
            tick();
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
